// File: rtl/ex_div_ctrl.sv
// ex_div_ctrl: EX-stage sequencer for the iterative divider; optional result cache under EX_DIV_CACHE_EN
module ex_div_ctrl (
   input  logic        clk,
   input  logic        reset,
   input  logic        issue_valid_i,
   input  logic [4:0]  issue_funct_i,
   input  logic [31:0] issue_op1_i,
   input  logic [31:0] issue_op2_i,
   input  logic [4:0]  issue_rd_i,
   input  logic        flush_i,
   output logic        stall_o,
   output logic        busy_o,
   output logic        div_stb_o,
   output logic [4:0]  div_funct_o,
   output logic [31:0] div_op1_o,
   output logic [31:0] div_op2_o,
   input  logic [31:0] div_res_i,
   input  logic        div_done_i,
   output logic        wb_valid_o,
   output logic [4:0]  wb_rd_o,
   output logic [31:0] wb_data_o
);
   typedef enum logic [4:0] {
      IDLE  = 5'b00001,
      REQ   = 5'b00010,
      WAIT  = 5'b00100,
      DRAIN = 5'b01000,
      WB    = 5'b10000
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  funct_q, funct_d, rd_q, rd_d;
   logic [31:0] op1_q, op1_d, op2_q, op2_d, res_q, res_d;
   logic        is_div, accept, sgn, quo, by_zero, ovf, special, hit, done_ok;
   logic [31:0] spec_res, hit_res;

   assign is_div   = issue_valid_i && (issue_funct_i inside {5'b10010, 5'b10011, 5'b10100, 5'b10101});
   assign accept   = is_div && !flush_i && (state_q == IDLE);
   assign sgn      = !issue_funct_i[0];
   assign quo      = !issue_funct_i[2];
   assign by_zero  = issue_op2_i == 32'd0;
   assign ovf      = sgn && issue_op1_i == 32'h8000_0000 && issue_op2_i == 32'hFFFF_FFFF;
   assign special  = by_zero || ovf;
   assign spec_res = by_zero ? (quo ? 32'hFFFF_FFFF : issue_op1_i) : (quo ? 32'h8000_0000 : 32'd0);
   assign done_ok  = (state_q == WAIT) && div_done_i && !flush_i;

`ifdef EX_DIV_CACHE_EN
   logic        c_v_q, c_v_d, c_sgn_q, c_sgn_d, c_qv_q, c_qv_d, c_rv_q, c_rv_d, c_same;
   logic [31:0] c_op1_q, c_op1_d, c_op2_q, c_op2_d, c_quo_q, c_quo_d, c_rem_q, c_rem_d;

   assign hit     = c_v_q && c_op1_q == issue_op1_i && c_op2_q == issue_op2_i &&
                    c_sgn_q == sgn && (quo ? c_qv_q : c_rv_q);
   assign hit_res = quo ? c_quo_q : c_rem_q;
   assign c_same  = c_v_q && c_op1_q == op1_q && c_op2_q == op2_q && c_sgn_q == !funct_q[0];

   // Record each divider result; a new operand pair discards the other half of the entry
   always_comb begin
      c_v_d   = c_v_q;
      c_sgn_d = c_sgn_q;
      c_qv_d  = c_qv_q;
      c_rv_d  = c_rv_q;
      c_op1_d = c_op1_q;
      c_op2_d = c_op2_q;
      c_quo_d = c_quo_q;
      c_rem_d = c_rem_q;
      if (done_ok) begin
         if (!c_same) begin
            c_v_d   = 1'b1;
            c_sgn_d = !funct_q[0];
            c_op1_d = op1_q;
            c_op2_d = op2_q;
            c_qv_d  = 1'b0;
            c_rv_d  = 1'b0;
         end
         if (!funct_q[2]) begin
            c_quo_d = div_res_i;
            c_qv_d  = 1'b1;
         end else begin
            c_rem_d = div_res_i;
            c_rv_d  = 1'b1;
         end
      end
   end

   // Cache storage, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         c_v_q   <= 1'b0;
         c_sgn_q <= 1'b0;
         c_qv_q  <= 1'b0;
         c_rv_q  <= 1'b0;
         c_op1_q <= '0;
         c_op2_q <= '0;
         c_quo_q <= '0;
         c_rem_q <= '0;
      end else begin
         c_v_q   <= c_v_d;
         c_sgn_q <= c_sgn_d;
         c_qv_q  <= c_qv_d;
         c_rv_q  <= c_rv_d;
         c_op1_q <= c_op1_d;
         c_op2_q <= c_op2_d;
         c_quo_q <= c_quo_d;
         c_rem_q <= c_rem_d;
      end
   end
`else
   assign hit     = 1'b0;
   assign hit_res = 32'd0;
`endif

   // Next state, operand latching and per-state outputs
   always_comb begin
      state_d    = state_q;
      funct_d    = funct_q;
      rd_d       = rd_q;
      op1_d      = op1_q;
      op2_d      = op2_q;
      res_d      = res_q;
      stall_o    = 1'b0;
      div_stb_o  = 1'b0;
      wb_valid_o = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               stall_o = 1'b1;
               funct_d = issue_funct_i;
               rd_d    = issue_rd_i;
               op1_d   = issue_op1_i;
               op2_d   = issue_op2_i;
               res_d   = special ? spec_res : hit_res;
               state_d = (special || hit) ? WB : REQ;
            end
         end
         REQ: begin
            stall_o   = 1'b1;
            div_stb_o = 1'b1;
            state_d   = flush_i ? DRAIN : WAIT;
         end
         WAIT: begin
            stall_o = 1'b1;
            res_d   = done_ok ? div_res_i : res_q;
            state_d = flush_i ? (div_done_i ? IDLE : DRAIN) : (div_done_i ? WB : WAIT);
         end
         DRAIN: begin
            stall_o = 1'b1;
            state_d = div_done_i ? IDLE : DRAIN;
         end
         WB: begin
            wb_valid_o = !flush_i;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and latch registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         funct_q <= '0;
         rd_q    <= '0;
         op1_q   <= '0;
         op2_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         funct_q <= funct_d;
         rd_q    <= rd_d;
         op1_q   <= op1_d;
         op2_q   <= op2_d;
         res_q   <= res_d;
      end
   end

   assign busy_o      = state_q != IDLE;
   assign div_funct_o = funct_q;
   assign div_op1_o   = op1_q;
   assign div_op2_o   = op2_q;
   assign wb_rd_o     = rd_q;
   assign wb_data_o   = res_q;
endmodule
